// File: rtl/sbp_lookup_injector.sv
// Head of the lookup pipeline: merges buffered lookups and unbuffered table updates
// onto the first stage's inputs, and tracks when each injected lookup leaves the tail.
module sbp_lookup_injector #(
    parameter int STAGE_ID_BITS = 6,
    parameter int LOCATION_BITS = 11,
    parameter int RESULT_BITS   = 24,
    parameter int FIFO_DEPTH    = 4,
    parameter int MAX_UPD_BURST = 4,
    parameter int PIPE_LATENCY  = 24,
    parameter int ROOT_STAGE_ID = 1,
    parameter int ROOT_LOCATION = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               lkp_valid_i,
    output logic                               lkp_ready_o,
    input  logic [31:0]                        lkp_ip_addr_i,
    input  logic                               upd_valid_i,
    output logic                               upd_ready_o,
    input  logic [31:0]                        upd_prefix_i,
    input  logic [5:0]                         upd_len_i,
    input  logic [STAGE_ID_BITS-1:0]           upd_stage_id_i,
    input  logic [LOCATION_BITS-1:0]           upd_location_i,
    input  logic [RESULT_BITS-1:0]             upd_result_i,
    output logic                               update_o,
    output logic [31:0]                        ip_addr_o,
    output logic [5:0]                         bit_pos_o,
    output logic [STAGE_ID_BITS-1:0]           stage_id_o,
    output logic [LOCATION_BITS-1:0]           location_o,
    output logic [RESULT_BITS-1:0]             result_o,
    output logic                               tail_valid_o,
    output logic [$clog2(PIPE_LATENCY+1)-1:0]  in_flight_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int BST_W = $clog2(MAX_UPD_BURST + 1);
    localparam int IF_W  = $clog2(PIPE_LATENCY + 1);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [BST_W-1:0] BURST_C = BST_W'(MAX_UPD_BURST);

    logic [31:0]             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        fifo_cnt;
    logic [CNT_W-1:0]        cnt_next;
    logic [BST_W-1:0]        burst_cnt;
    logic [PIPE_LATENCY-1:0] delay_line;
    logic                    fifo_empty;
    logic                    do_upd;
    logic                    do_lkp;
    logic                    push;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; ready never depends on valid, and valid must hold its payload until taken.
    assign fifo_empty   = (fifo_cnt == '0);
    assign upd_ready_o  = fifo_empty || (burst_cnt < BURST_C);
    assign do_upd       = upd_valid_i && upd_ready_o;
    assign do_lkp       = !do_upd && !fifo_empty;
    assign push         = lkp_valid_i && lkp_ready_o;
    assign tail_valid_o = delay_line[PIPE_LATENCY-1];

    always_comb begin
        cnt_next = fifo_cnt;
        case ({push, do_lkp})
            2'b10:   cnt_next = fifo_cnt + CNT_W'(1);
            2'b01:   cnt_next = fifo_cnt - CNT_W'(1);
            default: cnt_next = fifo_cnt;
        endcase
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= lkp_ip_addr_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            lkp_ready_o <= 1'b1;
            burst_cnt   <= '0;
            update_o    <= 1'b0;
            ip_addr_o   <= '0;
            bit_pos_o   <= '0;
            stage_id_o  <= '0;
            location_o  <= '0;
            result_o    <= '0;
            delay_line  <= '0;
            in_flight_o <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_lkp) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_cnt    <= cnt_next;
            lkp_ready_o <= (cnt_next != DEPTH_C);

            if (do_upd) begin
                if (burst_cnt < BURST_C) begin
                    burst_cnt <= burst_cnt + BST_W'(1);
                end
            end else begin
                burst_cnt <= '0;
            end

            if (do_upd) begin
                update_o   <= 1'b1;
                ip_addr_o  <= upd_prefix_i;
                bit_pos_o  <= upd_len_i;
                stage_id_o <= upd_stage_id_i;
                location_o <= upd_location_i;
                result_o   <= upd_result_i;
            end else if (do_lkp) begin
                update_o   <= 1'b0;
                ip_addr_o  <= fifo_mem[rd_ptr];
                bit_pos_o  <= '0;
                stage_id_o <= STAGE_ID_BITS'(ROOT_STAGE_ID);
                location_o <= LOCATION_BITS'(ROOT_LOCATION);
                result_o   <= '0;
            end else begin
                // Stage id 0 is never a real stage, so no stage acts on a bubble.
                update_o   <= 1'b0;
                ip_addr_o  <= '0;
                bit_pos_o  <= '0;
                stage_id_o <= '0;
                location_o <= '0;
                result_o   <= '0;
            end

            delay_line <= {delay_line[PIPE_LATENCY-2:0], do_lkp};
            case ({do_lkp, tail_valid_o})
                2'b10:   in_flight_o <= in_flight_o + IF_W'(1);
                2'b01:   in_flight_o <= in_flight_o - IF_W'(1);
                default: in_flight_o <= in_flight_o;
            endcase
        end
    end

endmodule

// File: tb/tb_sbp_lookup_injector.sv
// Bench for sbp_lookup_injector: directed vector table, multi-cycle corner sequences,
// and random traffic checked against a queue-based reference model.
module tb_sbp_lookup_injector;

    localparam int P     = 24;
    localparam int DEPTH = 4;
    localparam int MAXB  = 4;
    localparam int IFW   = $clog2(P + 1);

    typedef struct {
        logic        lv;
        logic [31:0] la;
        logic        uv;
        logic [31:0] up;
        logic [5:0]  ul;
        logic [5:0]  us;
        logic [10:0] uloc;
        logic [23:0] ures;
        logic        e_urdy;
        logic [79:0] e_out;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           lkp_valid_i;
    logic           lkp_ready_o;
    logic [31:0]    lkp_ip_addr_i;
    logic           upd_valid_i;
    logic           upd_ready_o;
    logic [31:0]    upd_prefix_i;
    logic [5:0]     upd_len_i;
    logic [5:0]     upd_stage_id_i;
    logic [10:0]    upd_location_i;
    logic [23:0]    upd_result_i;
    logic           update_o;
    logic [31:0]    ip_addr_o;
    logic [5:0]     bit_pos_o;
    logic [5:0]     stage_id_o;
    logic [10:0]    location_o;
    logic [23:0]    result_o;
    logic           tail_valid_o;
    logic [IFW-1:0] in_flight_o;
    logic [79:0]    dut_out;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [31:0] exp_q[$];
    int          m_burst;
    bit          m_lkp_rdy;
    bit          hist[$];
    logic [79:0] m_out;

    vec_t        tbl[8];
    logic [31:0] got_q[$];

    sbp_lookup_injector dut (
        .clk(clk), .rst(rst),
        .lkp_valid_i(lkp_valid_i), .lkp_ready_o(lkp_ready_o), .lkp_ip_addr_i(lkp_ip_addr_i),
        .upd_valid_i(upd_valid_i), .upd_ready_o(upd_ready_o), .upd_prefix_i(upd_prefix_i),
        .upd_len_i(upd_len_i), .upd_stage_id_i(upd_stage_id_i), .upd_location_i(upd_location_i),
        .upd_result_i(upd_result_i), .update_o(update_o), .ip_addr_o(ip_addr_o),
        .bit_pos_o(bit_pos_o), .stage_id_o(stage_id_o), .location_o(location_o),
        .result_o(result_o), .tail_valid_o(tail_valid_o), .in_flight_o(in_flight_o)
    );

    assign dut_out = {update_o, ip_addr_o, bit_pos_o, stage_id_o, location_o, result_o};

    // Clock
    always #5 clk = ~clk;

    function automatic logic [79:0] pack(logic u, logic [31:0] ip, logic [5:0] bp,
                                         logic [5:0] st, logic [10:0] loc, logic [23:0] res);
        return {u, ip, bp, st, loc, res};
    endfunction

    function automatic vec_t row(logic lv, logic [31:0] la, logic uv, logic [31:0] up,
                                 logic [5:0] ul, logic [5:0] us, logic [10:0] uloc,
                                 logic [23:0] ures, logic e_urdy, logic [79:0] e_out);
        vec_t r;
        r.lv = lv; r.la = la; r.uv = uv; r.up = up; r.ul = ul; r.us = us;
        r.uloc = uloc; r.ures = ures; r.e_urdy = e_urdy; r.e_out = e_out;
        return r;
    endfunction

    task automatic chk(string name, logic [79:0] act, logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        lkp_valid_i = 1'b0; lkp_ip_addr_i = '0; upd_valid_i = 1'b0; upd_prefix_i = '0;
        upd_len_i = '0; upd_stage_id_i = '0; upd_location_i = '0; upd_result_i = '0;
    endtask

    task automatic rand_upd_fields();
        upd_prefix_i   = $urandom;
        upd_len_i      = 6'($urandom_range(0, 32));
        upd_stage_id_i = 6'($urandom_range(1, 12));
        upd_location_i = 11'($urandom);
        upd_result_i   = 24'($urandom);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_burst   = 0;
        m_lkp_rdy = 1'b1;
        hist.delete();
        for (int i = 0; i < P; i++) hist.push_back(1'b0);
        m_out = '0;
    endtask

    // One clock: predict from the arbitration rules, advance, compare everything.
    task automatic step();
        bit          m_empty, m_urdy, do_u, do_l, psh;
        logic [31:0] head;
        int          inf;
        m_empty = (exp_q.size() == 0);
        m_urdy  = m_empty || (m_burst < MAXB);
        chk("upd_ready", 80'(upd_ready_o), 80'(m_urdy));
        chk("lkp_ready", 80'(lkp_ready_o), 80'(m_lkp_rdy));
        do_u = upd_valid_i && m_urdy;
        do_l = !do_u && !m_empty;
        psh  = lkp_valid_i && m_lkp_rdy;
        if (do_u) begin
            m_out   = pack(1'b1, upd_prefix_i, upd_len_i, upd_stage_id_i, upd_location_i, upd_result_i);
            m_burst = (m_burst < MAXB) ? m_burst + 1 : MAXB;
        end else if (do_l) begin
            head    = exp_q.pop_front();
            m_out   = pack(1'b0, head, 6'd0, 6'd1, 11'd0, 24'd0);
            m_burst = 0;
        end else begin
            m_out   = '0;
            m_burst = 0;
        end
        if (psh) exp_q.push_back(lkp_ip_addr_i);
        m_lkp_rdy = (exp_q.size() < DEPTH);
        hist.push_back(do_l);
        void'(hist.pop_front());
        @(posedge clk);
        #1;
        inf = 0;
        foreach (hist[i]) if (hist[i]) inf++;
        chk("outputs", dut_out, m_out);
        chk("tail_valid", 80'(tail_valid_o), 80'(hist[0]));
        chk("in_flight", 80'(in_flight_o), 80'(inf));
    endtask

    task automatic drain(int n);
        clear_inputs();
        repeat (n) step();
    endtask

    initial begin
        int k, idx, hi, max_inf, tail_cnt, first, last;
        bit saw_full, acc;

        tbl[0] = row(1'b1, 32'h11223344, 1'b0, 32'h0, 6'd0, 6'd0, 11'd0, 24'h0, 1'b1, 80'h0);
        tbl[1] = row(1'b0, 32'h0, 1'b1, 32'h0A000000, 6'd8, 6'd3, 11'd5, 24'h031054, 1'b1,
                     pack(1'b1, 32'h0A000000, 6'd8, 6'd3, 11'd5, 24'h031054));
        tbl[2] = row(1'b0, 32'h0, 1'b1, 32'h0B000000, 6'd16, 6'd4, 11'd7, 24'h041070, 1'b1,
                     pack(1'b1, 32'h0B000000, 6'd16, 6'd4, 11'd7, 24'h041070));
        tbl[3] = row(1'b0, 32'h0, 1'b1, 32'h0C000000, 6'd24, 6'd5, 11'd9, 24'h050090, 1'b1,
                     pack(1'b1, 32'h0C000000, 6'd24, 6'd5, 11'd9, 24'h050090));
        tbl[4] = row(1'b0, 32'h0, 1'b1, 32'h0D000000, 6'd32, 6'd6, 11'd11, 24'h0600B0, 1'b1,
                     pack(1'b1, 32'h0D000000, 6'd32, 6'd6, 11'd11, 24'h0600B0));
        tbl[5] = row(1'b0, 32'h0, 1'b1, 32'h0E000000, 6'd12, 6'd2, 11'd3, 24'h020030, 1'b0,
                     pack(1'b0, 32'h11223344, 6'd0, 6'd1, 11'd0, 24'h0));
        tbl[6] = row(1'b0, 32'h0, 1'b1, 32'h0E000000, 6'd12, 6'd2, 11'd3, 24'h020030, 1'b1,
                     pack(1'b1, 32'h0E000000, 6'd12, 6'd2, 11'd3, 24'h020030));
        tbl[7] = row(1'b0, 32'h0, 1'b0, 32'h0, 6'd0, 6'd0, 11'd0, 24'h0, 1'b1, 80'h0);

        // Reset
        rst = 1'b1;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", dut_out, 80'h0);
        chk("rst_lkp_ready", 80'(lkp_ready_o), 80'(1));
        chk("rst_in_flight", 80'(in_flight_o), 80'(0));
        chk("rst_tail", 80'(tail_valid_o), 80'(0));
        rst = 1'b0;

        // Vector table: update burst limit, update field mapping, lookup after 4 updates
        for (int i = 0; i < 8; i++) begin
            lkp_valid_i = tbl[i].lv; lkp_ip_addr_i = tbl[i].la; upd_valid_i = tbl[i].uv;
            upd_prefix_i = tbl[i].up; upd_len_i = tbl[i].ul; upd_stage_id_i = tbl[i].us;
            upd_location_i = tbl[i].uloc; upd_result_i = tbl[i].ures;
            chk("tbl_upd_ready", 80'(upd_ready_o), 80'(tbl[i].e_urdy));
            step();
            chk("tbl_out", dut_out, tbl[i].e_out);
        end
        drain(P + 2);

        // Single lookup: issue two edges after presentation, tail 24 edges after acceptance
        lkp_valid_i = 1'b1; lkp_ip_addr_i = 32'hC0A80101;
        step();
        lkp_valid_i = 1'b0;
        step();
        chk("t2_issue", dut_out, pack(1'b0, 32'hC0A80101, 6'd0, 6'd1, 11'd0, 24'd0));
        k = 1;
        while (!tail_valid_o && k < 40) begin
            step();
            k++;
        end
        chk("t2_tail_latency", 80'(k), 80'(24));
        step();
        chk("t2_tail_pulse", 80'(tail_valid_o), 80'(0));
        drain(4);

        // Five lookups against a saturating update stream, wrapping the FIFO
        got_q.delete();
        idx = 0;
        saw_full = 1'b0;
        for (int c = 0; c < 60 && idx < 5; c++) begin
            lkp_valid_i = 1'b1; lkp_ip_addr_i = 32'hA000_0000 + 32'(idx);
            upd_valid_i = 1'b1; rand_upd_fields();
            acc = lkp_ready_o;
            step();
            if (acc) idx++;
            if (!lkp_ready_o) saw_full = 1'b1;
            if (!update_o && stage_id_o == 6'd1) got_q.push_back(ip_addr_o);
        end
        lkp_valid_i = 1'b0;
        chk("t5_all_pushed", 80'(idx), 80'(5));
        chk("t5_ready_dropped", 80'(saw_full), 80'(1));
        for (int c = 0; c < 30; c++) begin
            rand_upd_fields();
            step();
            if (!update_o && stage_id_o == 6'd1) got_q.push_back(ip_addr_o);
        end
        chk("t5_issued_count", 80'(got_q.size()), 80'(5));
        for (int i = 0; i < 5 && i < got_q.size(); i++)
            chk("t5_order", 80'(got_q[i]), 80'(32'hA000_0000 + 32'(i)));
        drain(P + 2);

        // Thirty back-to-back lookups
        idx = 0; max_inf = 0; tail_cnt = 0; first = -1; last = -1;
        for (int c = 0; c < 140; c++) begin
            if (idx < 30) begin
                lkp_valid_i = 1'b1; lkp_ip_addr_i = $urandom;
            end else begin
                lkp_valid_i = 1'b0;
            end
            acc = lkp_valid_i && lkp_ready_o;
            step();
            if (acc) idx++;
            if (int'(in_flight_o) > max_inf) max_inf = int'(in_flight_o);
            if (tail_valid_o) begin
                tail_cnt++;
                if (first < 0) first = c;
                last = c;
            end
            if (idx >= 30 && c > 70) break;
        end
        chk("t6_in_flight_max", 80'(max_inf), 80'(P));
        chk("t6_tail_count", 80'(tail_cnt), 80'(30));
        chk("t6_tail_contig", 80'(last - first + 1), 80'(30));
        chk("t6_in_flight_end", 80'(in_flight_o), 80'(0));

        // Asynchronous reset in the middle of a lookup burst
        for (int i = 0; i < 2; i++) begin
            lkp_valid_i = 1'b1; lkp_ip_addr_i = 32'hBEEF_0000 + 32'(i);
            step();
        end
        #2;
        rst = 1'b1;
        #1;
        chk("t1_out_bubble", dut_out, 80'h0);
        chk("t1_lkp_ready", 80'(lkp_ready_o), 80'(1));
        chk("t1_in_flight", 80'(in_flight_o), 80'(0));
        clear_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        hi = 0;
        repeat (P) begin
            step();
            if (tail_valid_o) hi++;
        end
        chk("t1_tail_quiet", 80'(hi), 80'(0));

        // Random mixed traffic
        for (int c = 0; c < 600; c++) begin
            lkp_valid_i = ($urandom_range(0, 99) < 55);
            lkp_ip_addr_i = $urandom;
            upd_valid_i = ($urandom_range(0, 99) < 45);
            rand_upd_fields();
            step();
        end
        drain(P + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
